// File: rtl/two_op_dmem_port_pkg.sv
// Shared definitions for the two-op data memory port: default widths, A-stage
// actions and the layout of a queued request record {write, addr, wdata}.
package two_op_dmem_port_pkg;

  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_QUEUE_DEPTH = 2;

  typedef enum logic [1:0] {
    A_IDLE,
    A_LOAD,
    A_STORE,
    A_STALL
  } a_op_e;

  function automatic int req_width(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

  function automatic int req_addr_lsb(input int dw);
    return dw;
  endfunction

  function automatic int req_write_bit(input int aw, input int dw);
    return aw + dw;
  endfunction

endpackage

// File: rtl/two_op_dmem_port_req_fifo.sv
// Request queue between the core and the bus sequencer. Head entry is visible
// combinationally; a push while full is taken only when the head pops that cycle.
module two_op_req_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/two_op_dmem_port.sv
// CPU-side initiator for the two-op data memory bus: queues load/store requests
// and sequences them through an address stage and a read data stage.
module two_op_dmem_port
  import two_op_dmem_port_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              wr_done_o,
  output logic              busy_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] d_addr_o,
  inout  wire  [DATA_W-1:0] d_bus_io
);

  localparam int REQ_W    = req_width(ADDR_W, DATA_W);
  localparam int ADDR_LSB = req_addr_lsb(DATA_W);
  localparam int WR_BIT   = req_write_bit(ADDR_W, DATA_W);
  localparam int CW       = $clog2(QUEUE_DEPTH) + 1;

  logic [REQ_W-1:0]  push_rec, head_rec;
  logic              q_full, q_empty, q_pop;
  logic [CW-1:0]     q_count;
  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  a_op_e             a_op;

  logic              d_pend_q, d_pend_d;
  logic              wr_done_q, wr_done_d;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [ADDR_W-1:0] d_addr_q, d_addr_d;

  assign push_rec = {req_write_i, req_addr_i, req_wdata_i};

  two_op_req_fifo #(
    .W     (REQ_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (req_valid_i && req_ready_o),
    .wdata_i (push_rec),
    .pop_i   (q_pop),
    .rdata_o (head_rec),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  assign head_write = head_rec[WR_BIT];
  assign head_addr  = head_rec[ADDR_LSB +: ADDR_W];
  assign head_wdata = head_rec[DATA_W-1:0];

  // A store may not drive d_bus while the responder still owns it for a read.
  always_comb begin
    a_op = A_IDLE;
    if (!q_empty) begin
      if (head_write) a_op = d_pend_q ? A_STALL : A_STORE;
      else            a_op = A_LOAD;
    end
  end

  assign q_pop     = (a_op == A_LOAD) || (a_op == A_STORE);
  assign d_pend_d  = (a_op == A_LOAD);
  assign wr_done_d = (a_op == A_STORE);
  assign d_addr_d  = q_pop ? head_addr : d_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_pend_q    <= 1'b0;
      wr_done_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      d_addr_q    <= '0;
    end else begin
      d_pend_q    <= d_pend_d;
      wr_done_q   <= wr_done_d;
      rsp_valid_q <= d_pend_q;
      d_addr_q    <= d_addr_d;
      if (d_pend_q) rsp_rdata_q <= d_bus_io;
    end
  end

  assign req_ready_o = !q_full;
  assign busy_o      = (q_count != '0) || d_pend_q;
  assign mem_read_o  = d_pend_q;
  assign mem_write_o = (a_op == A_STORE);
  assign d_addr_o    = d_addr_d;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign wr_done_o   = wr_done_q;
  assign d_bus_io    = mem_write_o ? head_wdata : 'z;

endmodule

// File: tb/tb_two_op_dmem_port.sv
// Bench for two_op_dmem_port: registered-read memory on the data side and an
// in-order program-order reference of expected load data and store completions.
module tb_two_op_dmem_port;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, wr_done, busy, mem_read, mem_write;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] d_addr;
  wire  [DW-1:0] d_bus;

  always #5 clk = ~clk;

  two_op_dmem_port #(.ADDR_W(AW), .DATA_W(DW), .QUEUE_DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .wr_done_o   (wr_done),
    .busy_o      (busy),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .d_addr_o    (d_addr),
    .d_bus_io    (d_bus)
  );

  // Responder: registers the address every edge, drives d_bus while mem_read.
  logic [DW-1:0] bus_mem [0:65535];
  logic [DW-1:0] ref_mem [0:65535];
  logic [DW-1:0] rd_q = '0;

  always @(posedge clk) begin
    rd_q <= bus_mem[d_addr];
    if (mem_write) bus_mem[d_addr] = d_bus;
  end
  assign d_bus = mem_read ? rd_q : 'z;

  typedef struct {
    logic          wr;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  int            ld_cyc_q[$];
  logic [DW-1:0] ld_data_q[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            ld_cnt = 0;
  int            wr_cnt = 0;
  int            last_ld_lat = 0;
  int            last_wr_lat = 0;
  logic [DW-1:0] last_ld_data = '0;
  bit            saw_stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rd_wr_overlap", {31'd0, mem_read && mem_write}, 32'd0);
      if (req_valid && !req_ready) saw_stall = 1'b1;
      if (rsp_valid) begin
        chk("rsp_is_load_turn", {31'd0, exp_q.size() != 0 && !exp_q[0].wr}, 32'd1);
        if (exp_q.size() != 0 && !exp_q[0].wr) begin
          chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_q[0].data));
          last_ld_lat = cyc - exp_q[0].cyc;
          void'(exp_q.pop_front());
        end
        last_ld_data = rsp_rdata;
        ld_cyc_q.push_back(cyc);
        ld_data_q.push_back(rsp_rdata);
        ld_cnt++;
      end else begin
        chk("rsp_rdata_hold", 32'(rsp_rdata), 32'(last_ld_data));
      end
      if (wr_done) begin
        chk("wr_done_is_store_turn", {31'd0, exp_q.size() != 0 && exp_q[0].wr}, 32'd1);
        if (exp_q.size() != 0 && exp_q[0].wr) begin
          last_wr_lat = cyc - exp_q[0].cyc;
          void'(exp_q.pop_front());
        end
        wr_cnt++;
      end
      if (req_valid && req_ready) begin
        if (req_write) begin
          ref_mem[req_addr] = req_wdata;
          exp_q.push_back('{1'b1, req_wdata, cyc});
        end else begin
          exp_q.push_back('{1'b0, ref_mem[req_addr], cyc});
        end
      end
    end
  end

  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc;
    acc = 1'b0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      if (req_ready) acc = 1'b1;
    end
    chk("send_accept", {31'd0, acc}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_mem_read",  {31'd0, mem_read},  32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_d_addr",    32'(d_addr),        32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata),     32'd0);
    chk("rst_wr_done",   {31'd0, wr_done},   32'd0);
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    int            exp_lat;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   ld0, wr0;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

    for (int i = 0; i < 65536; i++) begin
      bus_mem[i] = DW'(i) ^ 16'hC3C3;
      ref_mem[i] = DW'(i) ^ 16'hC3C3;
    end
    for (int i = 0; i < 4; i++) begin
      bus_mem[i] = 16'h0011 * DW'(i + 1);
      ref_mem[i] = 16'h0011 * DW'(i + 1);
    end

    vecs[0] = '{1'b1, 16'hFFFF, 16'hAAAA, 16'h0000, 2};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0000, 16'hAAAA, 3};
    vecs[2] = '{1'b0, 16'h0001, 16'h0000, 16'h0022, 3};
    vecs[3] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 2};
    vecs[4] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 3};
    vecs[5] = '{1'b0, 16'h1234, 16'h0000, 16'hD1F7, 3};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset release
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_busy",      {31'd0, busy},      32'd0);
      chk("idle_mem_read",  {31'd0, mem_read},  32'd0);
      chk("idle_mem_write", {31'd0, mem_write}, 32'd0);
      chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
    end
    @(posedge clk);
    #1;

    // Isolated single operations with exact latency
    for (int i = 0; i < 6; i++) begin
      ld0 = ld_cnt;
      wr0 = wr_cnt;
      send(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      idle();
      drain();
      if (vecs[i].wr) begin
        chk("vec_wr_count", 32'(wr_cnt - wr0), 32'd1);
        chk("vec_wr_latency", 32'(last_wr_lat), 32'(vecs[i].exp_lat));
      end else begin
        chk("vec_ld_count", 32'(ld_cnt - ld0), 32'd1);
        chk("vec_ld_rdata", 32'(last_ld_data), 32'(vecs[i].exp_rdata));
        chk("vec_ld_latency", 32'(last_ld_lat), 32'(vecs[i].exp_lat));
      end
    end

    // Store then load to the same address: no bubble
    send(1'b1, 16'h0030, 16'h7777);
    send(1'b0, 16'h0030, 16'h0000);
    idle();
    drain();
    chk("st_ld_rdata", 32'(last_ld_data), 32'h7777);
    chk("st_ld_latency", 32'(last_ld_lat), 32'd3);

    // Four back-to-back loads
    ld_cyc_q.delete();
    ld_data_q.delete();
    for (int i = 0; i < 4; i++) send(1'b0, AW'(i), 16'h0000);
    idle();
    drain();
    chk("b2b_count", 32'(ld_cyc_q.size()), 32'd4);
    if (ld_cyc_q.size() == 4) begin
      for (int i = 0; i < 4; i++)
        chk("b2b_rdata", 32'(ld_data_q[i]), 32'h0011 * 32'(i + 1));
      for (int i = 1; i < 4; i++)
        chk("b2b_consecutive", 32'(ld_cyc_q[i] - ld_cyc_q[i-1]), 32'd1);
    end

    // Load then store: store waits one cycle
    send(1'b0, 16'h0005, 16'h0000);
    send(1'b1, 16'h0006, 16'h1234);
    idle();
    drain();
    chk("ld_st_wr_latency", 32'(last_wr_lat), 32'd3);
    chk("ld_st_mem6", 32'(bus_mem[6]), 32'h1234);
    chk("ld_st_rdata", 32'(last_ld_data), 32'h0005 ^ 32'hC3C3);

    // Alternating load/store with req_valid held: queue fills
    saw_stall = 1'b0;
    ld0 = ld_cnt;
    wr0 = wr_cnt;
    for (int i = 0; i < 6; i++) send(logic'(i % 2), 16'h0020 + AW'(i), 16'h5000 + DW'(i));
    idle();
    drain();
    chk("alt_saw_not_ready", {31'd0, saw_stall}, 32'd1);
    chk("alt_ld_count", 32'(ld_cnt - ld0), 32'd3);
    chk("alt_wr_count", 32'(wr_cnt - wr0), 32'd3);

    // Reset during a load's data stage
    send(1'b0, 16'h0003, 16'h0000);
    idle();
    for (int n = 0; n < 10 && !mem_read; n++) @(negedge clk);
    chk("rst_d_stage_reached", {31'd0, mem_read}, 32'd1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    last_ld_data = '0;
    #1 chk_reset_outputs();
    repeat (3) begin
      @(negedge clk);
      chk_reset_outputs();
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    ld0 = ld_cnt;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_no_stale_rsp", 32'(ld_cnt - ld0), 32'd0);
    send(1'b0, 16'h0002, 16'h0000);
    idle();
    drain();
    chk("rst_new_load_rdata", 32'(last_ld_data), 32'h0033);
    chk("rst_new_load_latency", 32'(last_ld_lat), 32'd3);

    // Randomised traffic over a small address window
    for (int i = 0; i < 300; i++) begin
      ra = 16'h0040 + AW'($urandom_range(0, 7));
      rd = DW'($urandom);
      send(logic'($urandom_range(0, 1)), ra, rd);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    idle();
    drain();
    for (int a = 16'h0040; a < 16'h0048; a++)
      chk("rand_mem_final", 32'(bus_mem[a]), 32'(ref_mem[a]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
